// File: rtl/down_timer_ctrl_if.sv
// Command/status bundle for the down_timer_ctrl countdown engine.
// master drives the commands; slave is the timer itself.
interface down_timer_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             pause;
  logic             stop;
  logic             auto_reload;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output start, pause, stop, auto_reload, load_val,
    input  count, busy, done
  );

  modport slave (
    input  start, pause, stop, auto_reload, load_val,
    output count, busy, done
  );
endinterface

// File: rtl/down_timer_ctrl.sv
// Programmable down-counter controller: one-shot or periodic with pause/stop.
// Optional tick prescaler enabled by defining DTC_PRESCALE_EN.
module down_timer_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic           clk,
  input  logic           rst,
  down_timer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] count, count_n;
  logic [WIDTH-1:0] reload, reload_n;
  logic             mode, mode_n;
  logic             done, done_n;
  logic             busy;
  logic             active;
  logic             tick;

  // A resume cycle (PAUSE with pause low) counts as a run cycle.
  assign active = (state != IDLE) && !bus.pause;

`ifdef DTC_PRESCALE_EN
  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] psc, psc_n;

  assign tick = (psc == PW'(PRESCALE - 1));

  always_comb begin
    psc_n = psc;
    if (bus.stop || bus.start) begin
      psc_n = '0;
    end else if (active) begin
      psc_n = tick ? '0 : psc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc <= '0;
    end else begin
      psc <= psc_n;
    end
  end
`else
  logic unused_prescale;
  assign unused_prescale = |PRESCALE;
  assign tick = 1'b1;
`endif

  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload;
    mode_n   = mode;
    done_n   = 1'b0;
    if (bus.stop && state != IDLE) begin
      state_n = IDLE;
      count_n = '0;
    end else if (bus.start && !bus.stop) begin
      state_n  = RUN;
      count_n  = bus.load_val;
      reload_n = bus.load_val;
      mode_n   = bus.auto_reload;
    end else begin
      case (state)
        RUN, PAUSE: begin
          if (bus.pause) begin
            state_n = PAUSE;
          end else begin
            state_n = RUN;
            if (tick) begin
              if (count != '0) begin
                count_n = count - 1'b1;
              end else begin
                done_n = 1'b1;
                if (mode) begin
                  count_n = reload;
                end else begin
                  state_n = IDLE;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      mode   <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      reload <= reload_n;
      mode   <= mode_n;
      done   <= done_n;
      busy   <= (state_n != IDLE);
    end
  end

  assign bus.count = count;
  assign bus.busy  = busy;
  assign bus.done  = done;

endmodule

// File: tb/tb_down_timer_ctrl.sv
// Directed-vector bench for down_timer_ctrl.
// Expected values are hand-computed per clock edge.
module tb_down_timer_ctrl;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  down_timer_ctrl_if #(.WIDTH(4)) bus ();

  down_timer_ctrl #(
    .WIDTH   (4),
    .PRESCALE(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic       pause;
    logic       stop;
    logic       ar;
    logic [3:0] lv;
    logic [3:0] c;
    logic       b;
    logic       d;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input logic r, input logic s, input logic p, input logic t,
    input logic a, input logic [3:0] lv,
    input logic [3:0] c, input logic b, input logic d
  );
    vec_t x;
    x.rst = r; x.start = s; x.pause = p; x.stop = t; x.ar = a;
    x.lv = lv; x.c = c; x.b = b; x.d = d;
    return x;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic p,
                       input logic t, input logic a, input logic [3:0] lv);
    @(negedge clk);
    rst = r;
    bus.start = s;
    bus.pause = p;
    bus.stop = t;
    bus.auto_reload = a;
    bus.load_val = lv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_done;
    int second_done;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.stop = 1'b0;
    bus.auto_reload = 1'b0;
    bus.load_val = '0;

    // reset, then one-shot of 3
    repeat (5) tbl.push_back(v(1,0,0,0,0,0, 0,0,0));
    tbl.push_back(v(0,1,0,0,0,3, 3,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 2,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 1,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,1));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0));
    // periodic of 2, then stop
    tbl.push_back(v(0,1,0,0,1,2, 2,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 1,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 2,1,1));
    tbl.push_back(v(0,0,0,0,0,0, 1,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 2,1,1));
    tbl.push_back(v(0,0,0,1,0,0, 0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0));
    // load 9, pause 4 cycles at 6
    tbl.push_back(v(0,1,0,0,0,9, 9,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 8,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 7,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 6,1,0));
    repeat (4) tbl.push_back(v(0,0,1,0,0,0, 6,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 5,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 4,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 3,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 2,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 1,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,1));
    // start+stop together, restart at count 0
    tbl.push_back(v(0,1,0,0,0,7, 7,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 6,1,0));
    tbl.push_back(v(0,1,0,1,0,5, 0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0));
    tbl.push_back(v(0,1,0,0,0,1, 1,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,1,0));
    tbl.push_back(v(0,1,0,0,0,5, 5,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 4,1,0));
    tbl.push_back(v(0,0,0,1,0,0, 0,0,0));
    // restart from PAUSE while pause held
    tbl.push_back(v(0,1,0,0,0,3, 3,1,0));
    tbl.push_back(v(0,0,1,0,0,0, 3,1,0));
    tbl.push_back(v(0,1,1,0,0,4, 4,1,0));
    tbl.push_back(v(0,0,1,0,0,0, 4,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 3,1,0));
    tbl.push_back(v(0,0,1,1,0,0, 0,0,0));
    // pause/stop ignored in IDLE
    tbl.push_back(v(0,0,1,1,0,0, 0,0,0));
    // rst mid-run, then load 0
    tbl.push_back(v(0,1,0,0,0,6, 6,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 5,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 4,1,0));
    tbl.push_back(v(1,0,0,0,0,0, 0,0,0));
    tbl.push_back(v(0,1,0,0,0,0, 0,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,1));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0));
    // rst drops a pending done
    tbl.push_back(v(0,1,0,0,0,0, 0,1,0));
    tbl.push_back(v(1,0,0,0,0,0, 0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0));
    // mode re-sampled on restart
    tbl.push_back(v(0,1,0,0,1,1, 1,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 1,1,1));
    tbl.push_back(v(0,1,0,0,0,0, 0,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,1));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0));

`ifndef DTC_PRESCALE_EN
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].start, tbl[i].pause,
            tbl[i].stop, tbl[i].ar, tbl[i].lv);
      chk($sformatf("v%0d.count", i), int'(bus.count), int'(tbl[i].c));
      chk($sformatf("v%0d.busy", i), int'(bus.busy), int'(tbl[i].b));
      chk($sformatf("v%0d.done", i), int'(bus.done), int'(tbl[i].d));
    end

    // periodic load 4: done every 5 cycles, bounded wait
    first_done = -1;
    second_done = -1;
    drive(0, 1, 0, 0, 1, 4);
    for (int k = 1; k <= 40; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      if (bus.done && first_done < 0) begin
        first_done = k;
      end else if (bus.done && second_done < 0) begin
        second_done = k;
        break;
      end
    end
    chk("period.first_done", first_done, 5);
    chk("period.second_done", second_done, 10);
    drive(0, 0, 0, 1, 0, 0);
    chk("period.stop_busy", int'(bus.busy), 0);
`else
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 1);
    chk("psc.start_count", int'(bus.count), 1);
    for (int k = 1; k <= 8; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk($sformatf("psc.e%0d.count", k), int'(bus.count), (k < 4) ? 1 : 0);
      chk($sformatf("psc.e%0d.busy", k), int'(bus.busy), (k < 8) ? 1 : 0);
      chk($sformatf("psc.e%0d.done", k), int'(bus.done), (k == 8) ? 1 : 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("psc.done_clear", int'(bus.done), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
